vscale_regfile_writer: RTL and testbench

- Write-side front end for the integer register file: the single point that drives the regfile write port (wen/wa/wd).
- Merges two writeback sources:
  - single-cycle pipeline results, which have priority and cannot stall;
  - long-latency results (mul/div, loads), which arrive over a valid/ready handshake and are buffered in a small FIFO.
- Keeps a per-register pending scoreboard so the hazard logic can tell when a regfile read would return stale data.

---
 rtl/vscale_regfile_writer_pkg.sv | 13 +
 rtl/vscale_wb_fifo.sv | 55 +++++
 rtl/vscale_regfile_writer.sv | 108 ++++++++++
 tb/tb_vscale_regfile_writer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_regfile_writer_pkg.sv
// Shared sizing defaults and helpers for the register-file write front end.
package vscale_regfile_writer_pkg;

    localparam int unsigned XPR_LEN_DEF        = 32;
    localparam int unsigned REG_ADDR_WIDTH_DEF = 5;
    localparam int unsigned FIFO_DEPTH_DEF     = 4;

    // Occupancy counter width able to represent 0..depth inclusive.
    function automatic int unsigned fifo_count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vscale_wb_fifo.sv
// In-order synchronous FIFO buffering long-latency writeback results.
module vscale_wb_fifo
    import vscale_regfile_writer_pkg::*;
#(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enq_valid,
    output logic                                enq_ready,
    input  logic [WIDTH-1:0]                    enq_data,
    output logic                                deq_valid,
    input  logic                                deq_en,
    output logic [WIDTH-1:0]                    deq_data,
    output logic [fifo_count_width(DEPTH)-1:0]  count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = fifo_count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             enq_fire;
    logic             deq_fire;

    assign enq_ready = (count < CW'(DEPTH));
    assign deq_valid = (count != '0);
    assign deq_data  = mem[rd_ptr];
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_en && deq_valid;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + PW'(1);
            if (deq_fire) rd_ptr <= rd_ptr + PW'(1);
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) mem[wr_ptr] <= enq_data;
    end

endmodule

// File: rtl/vscale_regfile_writer.sv
// Single driver of the regfile write port: arbitrates pipeline vs buffered
// long-latency results and tracks registers whose regfile value is stale.
module vscale_regfile_writer
    import vscale_regfile_writer_pkg::*;
#(
    parameter int unsigned XPR_LEN        = XPR_LEN_DEF,
    parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      pipe_wen,
    input  logic [REG_ADDR_WIDTH-1:0]                 pipe_wa,
    input  logic [XPR_LEN-1:0]                        pipe_wd,
    input  logic                                      lat_valid,
    output logic                                      lat_ready,
    input  logic [REG_ADDR_WIDTH-1:0]                 lat_wa,
    input  logic [XPR_LEN-1:0]                        lat_wd,
    input  logic                                      rsv_valid,
    input  logic [REG_ADDR_WIDTH-1:0]                 rsv_wa,
    input  logic [REG_ADDR_WIDTH-1:0]                 chk_ra1,
    input  logic [REG_ADDR_WIDTH-1:0]                 chk_ra2,
    output logic                                      chk_busy1,
    output logic                                      chk_busy2,
    output logic                                      wen,
    output logic [REG_ADDR_WIDTH-1:0]                 wa,
    output logic [XPR_LEN-1:0]                        wd,
    output logic [fifo_count_width(FIFO_DEPTH)-1:0]   fifo_count,
    output logic                                      idle
);

    localparam int unsigned NREG = 2 ** REG_ADDR_WIDTH;
    localparam int unsigned EW   = REG_ADDR_WIDTH + XPR_LEN;

    logic                      pipe_take;
    logic                      fifo_enq_valid;
    logic                      fifo_deq_valid;
    logic                      fifo_deq_en;
    logic [EW-1:0]             fifo_head;
    logic [REG_ADDR_WIDTH-1:0] head_wa;
    logic [XPR_LEN-1:0]        head_wd;
    logic [NREG-1:0]           pending_q;
    logic [NREG-1:0]           pending_d;

    // Results for x0 are accepted from the source but never buffered.
    assign fifo_enq_valid = lat_valid && (lat_wa != '0);
    assign pipe_take      = pipe_wen && (pipe_wa != '0);
    assign fifo_deq_en    = fifo_deq_valid && !pipe_take;
    assign head_wa        = fifo_head[EW-1:XPR_LEN];
    assign head_wd        = fifo_head[XPR_LEN-1:0];

    vscale_wb_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .enq_valid (fifo_enq_valid),
        .enq_ready (lat_ready),
        .enq_data  ({lat_wa, lat_wd}),
        .deq_valid (fifo_deq_valid),
        .deq_en    (fifo_deq_en),
        .deq_data  (fifo_head),
        .count     (fifo_count)
    );

    // Output register: pipeline has priority, otherwise drain the FIFO head.
    always_ff @(posedge clk) begin
        if (reset) begin
            wen <= 1'b0;
            wa  <= '0;
            wd  <= '0;
        end else if (pipe_take) begin
            wen <= 1'b1;
            wa  <= pipe_wa;
            wd  <= pipe_wd;
        end else if (fifo_deq_valid) begin
            wen <= 1'b1;
            wa  <= head_wa;
            wd  <= head_wd;
        end else begin
            wen <= 1'b0;
        end
    end

    // Clear on dequeue first so a same-cycle reservation of that register wins.
    always_comb begin
        pending_d = pending_q;
        if (fifo_deq_en) pending_d[head_wa] = 1'b0;
        if (rsv_valid && (rsv_wa != '0)) pending_d[rsv_wa] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    assign chk_busy1 = (chk_ra1 != '0) && (pending_q[chk_ra1] || (wen && (wa == chk_ra1)));
    assign chk_busy2 = (chk_ra2 != '0) && (pending_q[chk_ra2] || (wen && (wa == chk_ra2)));
    assign idle      = (fifo_count == '0) && !wen && (pending_q == '0);

    // A register released by this cycle's dequeue is free to be reserved again.
    rsv_not_pending_a: assert property (@(posedge clk) disable iff (reset)
        !(rsv_valid && (rsv_wa != '0) && pending_q[rsv_wa]
          && !(fifo_deq_en && (head_wa == rsv_wa))));

endmodule

// File: tb/tb_vscale_regfile_writer.sv
// Randomized scoreboard bench for vscale_regfile_writer with a queue-based reference model.
module tb_vscale_regfile_writer;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_wen, lat_valid, rsv_valid;
    logic [4:0]  pipe_wa, lat_wa, rsv_wa, chk_ra1, chk_ra2;
    logic [31:0] pipe_wd, lat_wd;
    logic        lat_ready, chk_busy1, chk_busy2, wen, idle;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [2:0]  fifo_count;

    int   checks = 0;
    int   errors = 0;
    ent_t mq[$];
    ent_t exp_q[$];
    bit   pend[32];
    bit   mwen;
    logic [4:0]  mwa;
    logic [31:0] mwd;
    bit   lat_hold;

    always #5 clk = ~clk;

    vscale_regfile_writer dut (
        .clk        (clk),
        .reset      (reset),
        .pipe_wen   (pipe_wen),
        .pipe_wa    (pipe_wa),
        .pipe_wd    (pipe_wd),
        .lat_valid  (lat_valid),
        .lat_ready  (lat_ready),
        .lat_wa     (lat_wa),
        .lat_wd     (lat_wd),
        .rsv_valid  (rsv_valid),
        .rsv_wa     (rsv_wa),
        .chk_ra1    (chk_ra1),
        .chk_ra2    (chk_ra2),
        .chk_busy1  (chk_busy1),
        .chk_busy2  (chk_busy2),
        .wen        (wen),
        .wa         (wa),
        .wd         (wd),
        .fifo_count (fifo_count),
        .idle       (idle)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pend_any();
        foreach (pend[i]) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_busy(input logic [4:0] ra);
        return (ra != 5'd0) && (pend[ra] || (mwen && (mwa == ra)));
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        mwen = 1'b0;
        mwa  = '0;
        mwd  = '0;
    endtask

    // Check visible state, advance one clock, then apply the same cycle to the model.
    task automatic step();
        int   sz;
        bit   rdy;
        ent_t e;
        #1;
        sz  = mq.size();
        rdy = (sz < 4);
        chk("wen", 32'(wen), 32'(mwen));
        chk("wa", 32'(wa), 32'(mwa));
        chk("wd", wd, mwd);
        chk("fifo_count", 32'(fifo_count), 32'(sz));
        chk("lat_ready", 32'(lat_ready), 32'(rdy));
        chk("busy1", 32'(chk_busy1), 32'(exp_busy(chk_ra1)));
        chk("busy2", 32'(chk_busy2), 32'(exp_busy(chk_ra2)));
        chk("idle", 32'(idle), 32'((sz == 0) && !mwen && !pend_any()));
        lat_hold = !reset && lat_valid && !rdy;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (pipe_wen && (pipe_wa != 5'd0)) begin
                e.wa = pipe_wa;
                e.wd = pipe_wd;
                mwen = 1'b1; mwa = e.wa; mwd = e.wd;
                exp_q.push_back(e);
            end else if (sz > 0) begin
                e = mq.pop_front();
                mwen = 1'b1; mwa = e.wa; mwd = e.wd;
                exp_q.push_back(e);
                pend[e.wa] = 1'b0;
            end else begin
                mwen = 1'b0;
            end
            if (rsv_valid && (rsv_wa != 5'd0)) pend[rsv_wa] = 1'b1;
            if (lat_valid && rdy && (lat_wa != 5'd0)) begin
                e.wa = lat_wa;
                e.wd = lat_wd;
                mq.push_back(e);
            end
        end
        #1;
    endtask

    task automatic quiet();
        reset     = 1'b0;
        pipe_wen  = 1'b0;
        lat_valid = 1'b0;
        rsv_valid = 1'b0;
    endtask

    task automatic rand_inputs();
        logic [4:0] r;
        reset    = ($urandom_range(0, 299) == 0);
        pipe_wen = ($urandom_range(0, 2) == 0);
        pipe_wa  = 5'($urandom);
        pipe_wd  = $urandom;
        if (!lat_hold) begin
            lat_valid = $urandom_range(0, 1) == 1;
            lat_wa    = 5'($urandom);
            lat_wd    = $urandom;
        end
        r         = 5'($urandom_range(1, 31));
        rsv_valid = !pend[r] && ($urandom_range(0, 3) == 0);
        rsv_wa    = r;
        chk_ra1   = 5'($urandom);
        chk_ra2   = (mwen && $urandom_range(0, 1) == 1) ? mwa : 5'($urandom);
    endtask

    // Every register write the DUT presents must be the next one the model expects.
    always @(negedge clk) begin
        ent_t e;
        if (reset === 1'b0 && wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("mon_unexpected_write", 32'(wen), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("mon_wa", 32'(wa), 32'(e.wa));
                chk("mon_wd", wd, e.wd);
            end
        end
    end

    initial begin
        quiet();
        reset   = 1'b1;
        pipe_wa = '0; pipe_wd = '0; lat_wa = '0; lat_wd = '0;
        rsv_wa  = '0; chk_ra1 = '0; chk_ra2 = '0;
        lat_hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;

        // Reset mid-operation discards reservation and buffered results.
        rsv_valid = 1'b1; rsv_wa = 5'd5; chk_ra1 = 5'd5; step();
        rsv_valid = 1'b0;
        pipe_wen = 1'b1; pipe_wa = 5'd1; pipe_wd = 32'h1;
        lat_valid = 1'b1; lat_wa = 5'd10; lat_wd = 32'hA; step();
        lat_wa = 5'd11; lat_wd = 32'hB; step();
        quiet(); reset = 1'b1; step();
        reset = 1'b0; step();
        chk("rst_fifo_count", 32'(fifo_count), 32'(0));
        chk("rst_busy5", 32'(chk_busy1), 32'(0));
        chk("rst_idle", 32'(idle), 32'(1));

        // Pipeline path, including a dropped write to x0.
        pipe_wen = 1'b1; pipe_wa = 5'd3; pipe_wd = 32'hDEADBEEF; chk_ra2 = 5'd3; step();
        pipe_wa = 5'd0; step();
        quiet(); step();

        // Long-latency path with reservation.
        rsv_valid = 1'b1; rsv_wa = 5'd7; chk_ra1 = 5'd7; step();
        rsv_valid = 1'b0;
        lat_valid = 1'b1; lat_wa = 5'd7; lat_wd = 32'h1234; step();
        lat_valid = 1'b0; repeat (3) step();

        // Pipeline starves the FIFO for three cycles.
        rsv_valid = 1'b1; rsv_wa = 5'd9; chk_ra1 = 5'd9;
        lat_valid = 1'b1; lat_wa = 5'd9; lat_wd = 32'h9999; step();
        quiet();
        pipe_wen = 1'b1; pipe_wa = 5'd4;
        for (int i = 0; i < 3; i++) begin pipe_wd = 32'h400 + 32'(i); step(); end
        pipe_wen = 1'b0; repeat (2) step();

        // Fill the FIFO behind a busy pipe, hold a fifth result, drain, repeat.
        for (int round = 0; round < 2; round++) begin
            pipe_wen = 1'b1;
            for (int i = 0; i < 4; i++) begin
                pipe_wa = 5'($urandom_range(1, 31)); pipe_wd = $urandom;
                lat_valid = 1'b1; lat_wa = 5'(12 + i); lat_wd = 32'hC000 + 32'(round * 16 + i);
                step();
            end
            lat_wa = 5'd20; lat_wd = 32'h2020 + 32'(round);
            step(); step();
            chk("full_count", 32'(fifo_count), 32'(4));
            chk("full_ready", 32'(lat_ready), 32'(0));
            pipe_wen = 1'b0;
            step(); step();
            lat_valid = 1'b0;
            repeat (6) step();
        end

        // Reservation of x7 lands on the cycle its entry is dequeued.
        chk_ra1 = 5'd7;
        rsv_valid = 1'b1; rsv_wa = 5'd7;
        lat_valid = 1'b1; lat_wa = 5'd7; lat_wd = 32'h7777; step();
        lat_valid = 1'b0; rsv_valid = 1'b1; rsv_wa = 5'd7; step();
        rsv_valid = 1'b0; step(); step();
        chk("rsv_wins_busy7", 32'(chk_busy1), 32'(1));
        // Enqueue and dequeue together, then release x7.
        lat_valid = 1'b1; lat_wa = 5'd21; lat_wd = 32'h2121; step();
        lat_wa = 5'd7; lat_wd = 32'h7070; step();
        quiet(); repeat (3) step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            step();
        end

        // Let everything drain.
        quiet(); reset = 1'b0; lat_hold = 1'b0;
        repeat (10) step();
        #6;
        chk("exp_q_drained", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
